// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the instruction-fetch stage:
// fetch FSM state encoding, the IF/ID metadata record and fetch constants.
package rv32i_types;

    // Fetch FSM states.
    //   S_START : first cycle out of reset, the request is issued from here
    //   S_WAIT  : a request is outstanding, waiting for imem_resp
    //   S_HOLD  : response already seen, decode stalled and holding its copy
    //   S_DROP  : the outstanding response belongs to a squashed path
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    // Metadata travelling with the fetched instruction into decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
        logic        valid;
    } if_id_stage_reg_t;

    // Byte-enable pattern for a full instruction-word read.
    localparam logic [3:0]  IMEM_RMASK_WORD = 4'hf;

    // Sequential PC increment.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Clears the two low address bits so every fetch address is word aligned.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hffff_fffc;

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch-stage performance counters: three independent 32-bit saturating
// event counters (requests issued, responses discarded, wait cycles).
// Only instantiated when IF_FETCH_PERF_CNT_EN is defined.
module if_perf_cnt
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_evt,
    input  logic        drop_evt,
    input  logic        wait_evt,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_wait_cnt
);

    localparam int N_CNT = 3;

    logic [N_CNT-1:0] evt;
    logic [31:0]      cnt_q [N_CNT];

    assign evt = {wait_evt, drop_evt, fetch_evt};

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            // Count the event, sticking at all-ones instead of wrapping.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q[gi] <= '0;
                end else if (evt[gi] && (cnt_q[gi] != 32'hffff_ffff)) begin
                    cnt_q[gi] <= cnt_q[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_fetch_cnt = cnt_q[0];
    assign perf_drop_cnt  = cnt_q[1];
    assign perf_wait_cnt  = cnt_q[2];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the in-order RV32I pipeline.
// Issues one instruction-memory read at a time, tracks it through
// S_START/S_WAIT/S_HOLD/S_DROP and presents PC/order metadata to decode.
// A redirect that lands while a read is in flight sends the FSM to S_DROP
// so the stale response is swallowed before the target is fetched.
// Optional: define IF_FETCH_PERF_CNT_EN to add fetch/drop/wait counters
// (extra output ports perf_fetch_cnt, perf_drop_cnt, perf_wait_cnt).
module if_fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          ORDER_W  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             move_pipeline,
    input  logic             forwarding_stall,
    input  logic             branch_flush,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic             imem_resp,
    output if_id_stage_reg_t if_id_stage_reg,
    output logic             if_ready
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_drop_cnt,
    output logic [31:0]      perf_wait_cnt
`endif
);

    localparam logic [ORDER_W-1:0] ORDER_ONE = ORDER_W'(1);

    fetch_state_t       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        redirect_q;
    logic [ORDER_W-1:0] order_q;
    logic [3:0]         rmask_q;

    logic               resp_live;
    logic               adv;
    logic [31:0]        pc_seq;
    logic [31:0]        flush_pc;

    // A response is usable either as it arrives in S_WAIT or from S_HOLD.
    assign resp_live = (state_q == S_WAIT) && imem_resp;
    assign if_ready  = resp_live || (state_q == S_HOLD);

    // Advance only when the whole pipeline moves and no redirect competes.
    assign adv = move_pipeline && !forwarding_stall && !branch_flush && if_ready;

    assign pc_seq   = pc_q + PC_STEP;
    assign flush_pc = branch_target & PC_ALIGN_MASK;

    // Fetch FSM: state, PC, order, pending redirect and the request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_START;
            pc_q       <= RESET_PC;
            redirect_q <= RESET_PC;
            order_q    <= '0;
            rmask_q    <= '0;
        end else begin
            // The request strobe is a one-cycle pulse; each branch that
            // launches a new read raises it again.
            rmask_q <= '0;
            unique case (state_q)
                S_START: begin
                    // Nothing is outstanding yet, so a redirect simply
                    // changes where the first read goes.
                    if (branch_flush) begin
                        pc_q <= flush_pc;
                    end
                    rmask_q <= IMEM_RMASK_WORD;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (branch_flush) begin
                        if (imem_resp) begin
                            // Response arrives with the redirect: drop it
                            // and fetch the target straight away.
                            pc_q    <= flush_pc;
                            rmask_q <= IMEM_RMASK_WORD;
                        end else begin
                            // Read still in flight: remember the target
                            // and wait for the stale response to drain.
                            redirect_q <= flush_pc;
                            state_q    <= S_DROP;
                        end
                    end else if (adv) begin
                        pc_q    <= pc_seq;
                        order_q <= order_q + ORDER_ONE;
                        rmask_q <= IMEM_RMASK_WORD;
                    end else if (imem_resp) begin
                        // Decode latched the word; keep the metadata stable.
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (branch_flush) begin
                        pc_q    <= flush_pc;
                        rmask_q <= IMEM_RMASK_WORD;
                        state_q <= S_WAIT;
                    end else if (adv) begin
                        pc_q    <= pc_seq;
                        order_q <= order_q + ORDER_ONE;
                        rmask_q <= IMEM_RMASK_WORD;
                        state_q <= S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_resp) begin
                        // Stale read retired: the newest redirect wins.
                        pc_q    <= branch_flush ? flush_pc : redirect_q;
                        rmask_q <= IMEM_RMASK_WORD;
                        state_q <= S_WAIT;
                    end else if (branch_flush) begin
                        redirect_q <= flush_pc;
                    end
                end
                default: begin
                    state_q <= S_START;
                end
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign imem_rmask = rmask_q;

    // Metadata for decode; only live or held fetches are marked valid.
    always_comb begin
        if_id_stage_reg         = '0;
        if_id_stage_reg.pc      = pc_q;
        if_id_stage_reg.pc_next = pc_seq;
        if_id_stage_reg.order   = 64'(order_q);
        if_id_stage_reg.valid   = (state_q == S_WAIT) || (state_q == S_HOLD);
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic drop_evt;
    logic wait_evt;

    // A read is issued in every cycle the strobe is high.
    assign fetch_evt = (rmask_q == IMEM_RMASK_WORD);
    // Responses thrown away: drained in S_DROP, or usable but squashed by a
    // redirect (live in S_WAIT or held in S_HOLD).
    assign drop_evt  = ((state_q == S_DROP) && imem_resp) || (branch_flush && if_ready);
    assign wait_evt  = (state_q == S_WAIT) && !imem_resp;

    if_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_evt      (fetch_evt),
        .drop_evt       (drop_evt),
        .wait_evt       (wait_evt),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, first fetch, hold/stall,
// redirects (in flight, coincident with response, repeated), back-to-back
// fetches, PC wrap and asynchronous reset in the middle of a wait.
module tb_if_fetch_stage;
    import rv32i_types::*;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             move_pipeline;
    logic             forwarding_stall;
    logic             branch_flush;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic [3:0]       imem_rmask;
    logic             imem_resp;
    if_id_stage_reg_t if_id_stage_reg;
    logic             if_ready;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0]      perf_fetch_cnt;
    logic [31:0]      perf_drop_cnt;
    logic [31:0]      perf_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC (RST_PC),
        .ORDER_W  (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .move_pipeline    (move_pipeline),
        .forwarding_stall (forwarding_stall),
        .branch_flush     (branch_flush),
        .branch_target    (branch_target),
        .imem_addr        (imem_addr),
        .imem_rmask       (imem_rmask),
        .imem_resp        (imem_resp),
        .if_id_stage_reg  (if_id_stage_reg),
        .if_ready         (if_ready)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_drop_cnt    (perf_drop_cnt),
        .perf_wait_cnt    (perf_wait_cnt)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL reset_rmask got %h want %h", imem_rmask, 4'h0); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, RST_PC); end
        checks++; if (if_id_stage_reg.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_id_stage_reg.valid); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", if_ready); end
        checks++; if (if_id_stage_reg.order !== 64'd0) begin errors++; $display("FAIL reset_order got %0d want 0", if_id_stage_reg.order); end
        rst_n = 1'b1;
        $display("test_reset: reset released");
    endtask

    task automatic test_first_fetch();
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL ff_req_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h1eceb000) begin errors++; $display("FAIL ff_req_addr got %h want 1eceb000", imem_addr); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL ff_req_ready got %b want 0", if_ready); end
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL ff_pulse_rmask got %h want 0", imem_rmask); end
        @(negedge clk);
        imem_resp = 1'b1; move_pipeline = 1'b1; #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL ff_resp_ready got %b want 1", if_ready); end
        checks++; if (if_id_stage_reg.valid !== 1'b1) begin errors++; $display("FAIL ff_resp_valid got %b want 1", if_id_stage_reg.valid); end
        checks++; if (if_id_stage_reg.pc !== 32'h1eceb000) begin errors++; $display("FAIL ff_resp_pc got %h want 1eceb000", if_id_stage_reg.pc); end
        checks++; if (if_id_stage_reg.pc_next !== 32'h1eceb004) begin errors++; $display("FAIL ff_resp_pc_next got %h want 1eceb004", if_id_stage_reg.pc_next); end
        checks++; if (if_id_stage_reg.order !== 64'd0) begin errors++; $display("FAIL ff_resp_order got %0d want 0", if_id_stage_reg.order); end
        @(negedge clk);
        imem_resp = 1'b0; #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL ff_next_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h1eceb004) begin errors++; $display("FAIL ff_next_addr got %h want 1eceb004", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd1) begin errors++; $display("FAIL ff_next_order got %0d want 1", if_id_stage_reg.order); end
        $display("test_first_fetch: fetch 1eceb000 order 0 retired");
    endtask

    task automatic test_hold();
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL hold_pre_rmask got %h want 0", imem_rmask); end
        imem_resp = 1'b1; move_pipeline = 1'b0; #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL hold_resp_ready got %b want 1", if_ready); end
        @(negedge clk);
        imem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL hold_rmask[%0d] got %h want 0", i, imem_rmask); end
            checks++; if (if_id_stage_reg.pc !== 32'h1eceb004) begin errors++; $display("FAIL hold_pc[%0d] got %h want 1eceb004", i, if_id_stage_reg.pc); end
            checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL hold_ready[%0d] got %b want 1", i, if_ready); end
        end
        move_pipeline = 1'b1; forwarding_stall = 1'b1;
        @(negedge clk); #1;
        checks++; if (if_id_stage_reg.pc !== 32'h1eceb004) begin errors++; $display("FAIL hold_stall_pc got %h want 1eceb004", if_id_stage_reg.pc); end
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL hold_stall_rmask got %h want 0", imem_rmask); end
        forwarding_stall = 1'b0;
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL hold_adv_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h1eceb008) begin errors++; $display("FAIL hold_adv_addr got %h want 1eceb008", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd2) begin errors++; $display("FAIL hold_adv_order got %0d want 2", if_id_stage_reg.order); end
        $display("test_hold: held 1eceb004 then advanced");
    endtask

    task automatic test_flush_wait();
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL fw_pre_rmask got %h want 0", imem_rmask); end
        branch_flush = 1'b1; branch_target = 32'h1eceb103;
        @(negedge clk);
        branch_flush = 1'b0; #1;
        checks++; if (if_id_stage_reg.valid !== 1'b0) begin errors++; $display("FAIL fw_drop_valid got %b want 0", if_id_stage_reg.valid); end
        checks++; if (imem_addr !== 32'h1eceb008) begin errors++; $display("FAIL fw_drop_addr got %h want 1eceb008", imem_addr); end
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL fw_drop_rmask got %h want 0", imem_rmask); end
        @(negedge clk);
        imem_resp = 1'b1; #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL fw_stale_ready got %b want 0", if_ready); end
        checks++; if (if_id_stage_reg.valid !== 1'b0) begin errors++; $display("FAIL fw_stale_valid got %b want 0", if_id_stage_reg.valid); end
        @(negedge clk);
        imem_resp = 1'b0; #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL fw_tgt_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h1eceb100) begin errors++; $display("FAIL fw_tgt_addr got %h want 1eceb100", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd2) begin errors++; $display("FAIL fw_tgt_order got %0d want 2", if_id_stage_reg.order); end
        $display("test_flush_wait: stale response dropped, redirect to 1eceb100");
    endtask

    task automatic test_flush_with_resp();
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL fr_pre_rmask got %h want 0", imem_rmask); end
        imem_resp = 1'b1; branch_flush = 1'b1; branch_target = 32'h1eceb200;
        @(negedge clk);
        imem_resp = 1'b0; branch_flush = 1'b0; #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL fr_tgt_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h1eceb200) begin errors++; $display("FAIL fr_tgt_addr got %h want 1eceb200", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd2) begin errors++; $display("FAIL fr_tgt_order got %0d want 2", if_id_stage_reg.order); end
        $display("test_flush_with_resp: coincident response discarded");
    endtask

    task automatic test_double_flush();
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL df_pre_rmask got %h want 0", imem_rmask); end
        branch_flush = 1'b1; branch_target = 32'h00000100;
        @(negedge clk);
        branch_target = 32'h00000200; #1;
        checks++; if (if_id_stage_reg.valid !== 1'b0) begin errors++; $display("FAIL df_drop_valid got %b want 0", if_id_stage_reg.valid); end
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL df_drop1_rmask got %h want 0", imem_rmask); end
        @(negedge clk);
        branch_flush = 1'b0; #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL df_drop2_rmask got %h want 0", imem_rmask); end
        checks++; if (imem_addr !== 32'h1eceb200) begin errors++; $display("FAIL df_drop_addr got %h want 1eceb200", imem_addr); end
        imem_resp = 1'b1;
        @(negedge clk);
        imem_resp = 1'b0; #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL df_tgt_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h00000200) begin errors++; $display("FAIL df_tgt_addr got %h want 00000200", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd2) begin errors++; $display("FAIL df_tgt_order got %0d want 2", if_id_stage_reg.order); end
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL df_post_rmask got %h want 0", imem_rmask); end
        $display("test_double_flush: only request went to 00000200");
    endtask

    task automatic test_back_to_back();
        imem_resp = 1'b1; move_pipeline = 1'b1; #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL bb_r0_ready got %b want 1", if_ready); end
        checks++; if (if_id_stage_reg.pc !== 32'h00000200) begin errors++; $display("FAIL bb_r0_pc got %h want 00000200", if_id_stage_reg.pc); end
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL bb_r1_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h00000204) begin errors++; $display("FAIL bb_r1_addr got %h want 00000204", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd3) begin errors++; $display("FAIL bb_r1_order got %0d want 3", if_id_stage_reg.order); end
        @(negedge clk);
        imem_resp = 1'b0; #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL bb_r2_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== 32'h00000208) begin errors++; $display("FAIL bb_r2_addr got %h want 00000208", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd4) begin errors++; $display("FAIL bb_r2_order got %0d want 4", if_id_stage_reg.order); end
        $display("test_back_to_back: requests 204 and 208 issued consecutively");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        imem_resp = 1'b1; branch_flush = 1'b1; branch_target = 32'hffffffff;
        @(negedge clk);
        imem_resp = 1'b0; branch_flush = 1'b0; #1;
        checks++; if (imem_addr !== 32'hfffffffc) begin errors++; $display("FAIL wr_addr got %h want fffffffc", imem_addr); end
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL wr_rmask got %h want f", imem_rmask); end
        checks++; if (if_id_stage_reg.pc_next !== 32'h00000000) begin errors++; $display("FAIL wr_pc_next got %h want 00000000", if_id_stage_reg.pc_next); end
        @(negedge clk);
        imem_resp = 1'b1; #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", if_ready); end
        @(negedge clk);
        imem_resp = 1'b0; #1;
        checks++; if (imem_addr !== 32'h00000000) begin errors++; $display("FAIL wr_adv_addr got %h want 00000000", imem_addr); end
        checks++; if (if_id_stage_reg.order !== 64'd5) begin errors++; $display("FAIL wr_adv_order got %0d want 5", if_id_stage_reg.order); end
        $display("test_wrap: pc wrapped from fffffffc to 00000000");
    endtask

    task automatic test_async_reset();
        @(negedge clk); #1;
        checks++; if (if_id_stage_reg.valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", if_id_stage_reg.valid); end
        #2;
        rst_n = 1'b0; #1;
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL ar_addr got %h want %h", imem_addr, RST_PC); end
        checks++; if (if_id_stage_reg.order !== 64'd0) begin errors++; $display("FAIL ar_order got %0d want 0", if_id_stage_reg.order); end
        checks++; if (if_id_stage_reg.valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", if_id_stage_reg.valid); end
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL ar_rmask got %h want 0", imem_rmask); end
        @(negedge clk);
        imem_resp = 1'b1; #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL ar_stale_ready got %b want 0", if_ready); end
        @(negedge clk);
        imem_resp = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'hf) begin errors++; $display("FAIL ar_req_rmask got %h want f", imem_rmask); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL ar_req_addr got %h want %h", imem_addr, RST_PC); end
        checks++; if (if_id_stage_reg.valid !== 1'b1) begin errors++; $display("FAIL ar_req_valid got %b want 1", if_id_stage_reg.valid); end
        @(negedge clk); #1;
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL ar_post_rmask got %h want 0", imem_rmask); end
        $display("test_async_reset: fresh request to reset pc after reset");
    endtask

    initial begin
        rst_n            = 1'b0;
        move_pipeline    = 1'b0;
        forwarding_stall = 1'b0;
        branch_flush     = 1'b0;
        branch_target    = 32'h0;
        imem_resp        = 1'b0;

        test_reset();
        test_first_fetch();
        test_hold();
        test_flush_wait();
        test_flush_with_resp();
        test_double_flush();
        test_back_to_back();
        test_wrap();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
